// File: rtl/er_pa_frame_scheduler_pkg.sv
// Shared constants, pa_status bit positions and FSM encoding for the PA frame scheduler.
package er_pa_frame_scheduler_pkg;

   localparam int PA_FRAME_WORDS = 128;
   localparam int PA_SEC_MARGIN  = 64;
   localparam int PA_ERR_THRESH  = 901;

   localparam int PA_ADDR_W   = 15;
   localparam int PA_CNT_W    = 16;
   localparam int PA_STATUS_W = 3;

   localparam int ST_QBER_ABORT = 0;
   localparam int ST_VERIF_FAIL = 1;
   localparam int ST_MALFORMED  = 2;

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_CALC    = 2'd1,
      S_PUSH    = 2'd2
   } pa_state_e;

   // Packed descriptor: {base_addr, word_cnt, secure_len, status, parity}
   function automatic int pa_desc_w(input int len_w);
      return PA_ADDR_W + PA_CNT_W + len_w + PA_STATUS_W + 1;
   endfunction

endpackage

// File: rtl/er_pa_frame_scheduler_desc_fifo.sv
// Show-ahead synchronous descriptor FIFO; read data valid whenever not empty.
// A push into a full FIFO succeeds when a pop happens on the same edge; otherwise it is ignored.
module er_pa_frame_scheduler_desc_fifo #(
   parameter int W     = 49,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   input  logic         rd_rdy,
   output logic [W-1:0] rd_dat,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push, pop;

   always_comb begin
      empty    = (cnt_q == '0);
      full     = (cnt_q == (AW+1)'(DEPTH));
      rd_dat   = mem_q[rd_ptr_q];
      pop      = rd_rdy && !empty;
      push     = wr_vld && (!full || pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_dat;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/er_pa_frame_scheduler.sv
// Builds one PA descriptor per reconciled frame from snooped BRAM writes and the frame report.
// Descriptor reaches the FIFO 2 cycles after frame_param_valid; pa_ready stalls pops, a full FIFO drops and flags.
module er_pa_frame_scheduler
   import er_pa_frame_scheduler_pkg::*;
#(
   parameter int FRAME_WORDS = PA_FRAME_WORDS,
   parameter int LEAK_W      = 16,
   parameter int ERR_W       = 12,
   parameter int LEN_W       = 14,
   parameter int SEC_MARGIN  = PA_SEC_MARGIN,
   parameter int ERR_THRESH  = PA_ERR_THRESH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rk_ena,
   input  logic              rk_wea,
   input  logic [14:0]       rk_addra,
   input  logic [63:0]       rk_dina,
   input  logic [LEAK_W-1:0] frame_leaked_info,
   input  logic [ERR_W-1:0]  frame_error_count,
   input  logic              frame_param_valid,
   input  logic              frame_verif_fail,
   output logic              pa_valid,
   input  logic              pa_ready,
   output logic [14:0]       pa_base_addr,
   output logic [15:0]       pa_word_cnt,
   output logic [LEN_W-1:0]  pa_secure_len,
   output logic [2:0]        pa_status,
   output logic              pa_parity,
   output logic              overflow_err,
   output logic              protocol_err,
   output logic [15:0]       frames_done
);

   localparam int DW = pa_desc_w(LEN_W);
   localparam logic signed [LEAK_W+1:0] FRAME_BITS = (LEAK_W+2)'(FRAME_WORDS * 64);
   localparam logic signed [LEAK_W+1:0] MARGIN     = (LEAK_W+2)'(SEC_MARGIN);
   localparam logic signed [LEAK_W+1:0] LEN_MAX    = (LEAK_W+2)'((1 << LEN_W) - 1);

   pa_state_e              state_q, state_d;
   // Live accumulators for the frame being written; they run in every state.
   logic [PA_CNT_W-1:0]    cnt_q, cnt_d;
   logic                   par_q, par_d;
   logic [PA_ADDR_W-1:0]   base_q, base_d;
   logic                   have_q, have_d;
   // Snapshot of the closing frame.
   logic [PA_CNT_W-1:0]    fr_cnt_q, fr_cnt_d;
   logic                   fr_par_q, fr_par_d;
   logic [PA_ADDR_W-1:0]   fr_base_q, fr_base_d;
   logic [LEAK_W-1:0]      leak_q, leak_d;
   logic [ERR_W-1:0]       err_q, err_d;
   logic                   fail_q, fail_d;
   logic [LEN_W-1:0]       sec_q, sec_d;
   logic [2:0]             status_q, status_d;
   logic [15:0]            done_q, done_d;
   logic                   ovf_q, ovf_d;
   logic                   proto_q, proto_d;

   logic                   wr, close, push_ok, fifo_full, fifo_empty;
   logic signed [LEAK_W+1:0] diff;
   logic [LEN_W-1:0]       sat_c;
   logic [2:0]             st_c;
   logic [DW-1:0]          fifo_wr_dat, fifo_rd_dat;

   always_comb begin
      wr      = rk_ena && rk_wea;
      close   = frame_param_valid && (state_q == S_COLLECT);
      push_ok = !fifo_full || (pa_valid && pa_ready);

      diff = FRAME_BITS - $signed({2'b00, leak_q}) - MARGIN;
      if (diff[LEAK_W+1]) begin
         sat_c = '0;
      end else if (diff > LEN_MAX) begin
         sat_c = LEN_MAX[LEN_W-1:0];
      end else begin
         sat_c = diff[LEN_W-1:0];
      end
      st_c                = '0;
      st_c[ST_MALFORMED]  = (fr_cnt_q != PA_CNT_W'(FRAME_WORDS));
      st_c[ST_VERIF_FAIL] = fail_q;
      st_c[ST_QBER_ABORT] = (err_q > ERR_W'(ERR_THRESH));

      state_d   = state_q;
      cnt_d     = cnt_q;
      par_d     = par_q;
      base_d    = base_q;
      have_d    = have_q;
      fr_cnt_d  = fr_cnt_q;
      fr_par_d  = fr_par_q;
      fr_base_d = fr_base_q;
      leak_d    = leak_q;
      err_d     = err_q;
      fail_d    = fail_q;
      sec_d     = sec_q;
      status_d  = status_q;
      done_d    = done_q;
      ovf_d     = ovf_q;
      proto_d   = proto_q;

      // A write coincident with the closing pulse belongs to the closing frame.
      if (close) begin
         fr_cnt_d  = cnt_q + PA_CNT_W'(wr);
         fr_par_d  = par_q ^ (wr && (^rk_dina));
         fr_base_d = (wr && !have_q) ? rk_addra : base_q;
         leak_d    = frame_leaked_info;
         err_d     = frame_error_count;
         fail_d    = frame_verif_fail;
         cnt_d     = '0;
         par_d     = 1'b0;
         have_d    = 1'b0;
      end else if (wr) begin
         cnt_d = cnt_q + PA_CNT_W'(1);
         par_d = par_q ^ (^rk_dina);
         if (!have_q) begin
            base_d = rk_addra;
            have_d = 1'b1;
         end
      end

      if (frame_param_valid && (state_q != S_COLLECT)) begin
         proto_d = 1'b1;
      end

      case (state_q)
         S_COLLECT: begin
            if (close) state_d = S_CALC;
         end
         S_CALC: begin
            status_d = st_c;
            sec_d    = (st_c != 3'b000) ? '0 : sat_c;
            state_d  = S_PUSH;
         end
         S_PUSH: begin
            if (push_ok) done_d = done_q + 16'd1;
            else         ovf_d  = 1'b1;
            state_d = S_COLLECT;
         end
         default: state_d = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_COLLECT;
         cnt_q     <= '0;
         par_q     <= 1'b0;
         base_q    <= '0;
         have_q    <= 1'b0;
         fr_cnt_q  <= '0;
         fr_par_q  <= 1'b0;
         fr_base_q <= '0;
         leak_q    <= '0;
         err_q     <= '0;
         fail_q    <= 1'b0;
         sec_q     <= '0;
         status_q  <= '0;
         done_q    <= '0;
         ovf_q     <= 1'b0;
         proto_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         par_q     <= par_d;
         base_q    <= base_d;
         have_q    <= have_d;
         fr_cnt_q  <= fr_cnt_d;
         fr_par_q  <= fr_par_d;
         fr_base_q <= fr_base_d;
         leak_q    <= leak_d;
         err_q     <= err_d;
         fail_q    <= fail_d;
         sec_q     <= sec_d;
         status_q  <= status_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         proto_q   <= proto_d;
      end
   end

   assign fifo_wr_dat = {fr_base_q, fr_cnt_q, sec_q, status_q, fr_par_q};

   er_pa_frame_scheduler_desc_fifo #(
      .W     (DW),
      .DEPTH (4)
   ) u_desc_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_vld (state_q == S_PUSH),
      .wr_dat (fifo_wr_dat),
      .rd_rdy (pa_ready),
      .rd_dat (fifo_rd_dat),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign pa_valid = !fifo_empty;
   assign {pa_base_addr, pa_word_cnt, pa_secure_len, pa_status, pa_parity} = fifo_rd_dat;
   assign overflow_err = ovf_q;
   assign protocol_err = proto_q;
   assign frames_done  = done_q;

endmodule

// File: tb/tb_er_pa_frame_scheduler.sv
// Scoreboard bench: expected descriptors are queued when a frame closes and compared on each PA transfer.
module tb_er_pa_frame_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rk_ena = 1'b0, rk_wea = 1'b0;
   logic [14:0] rk_addra = '0;
   logic [63:0] rk_dina = '0;
   logic [15:0] frame_leaked_info = '0;
   logic [11:0] frame_error_count = '0;
   logic        frame_param_valid = 1'b0, frame_verif_fail = 1'b0;
   logic        pa_valid, pa_ready = 1'b0;
   logic [14:0] pa_base_addr;
   logic [15:0] pa_word_cnt;
   logic [13:0] pa_secure_len;
   logic [2:0]  pa_status;
   logic        pa_parity, overflow_err, protocol_err;
   logic [15:0] frames_done;

   typedef struct {
      logic [14:0] base;
      logic [15:0] cnt;
      logic [13:0] sec;
      logic [2:0]  st;
      logic        par;
   } desc_t;

   desc_t exp_q[$];
   int    total = 0;
   int    bad = 0;
   int    exp_done = 0;

   always #5 clk = ~clk;

   er_pa_frame_scheduler dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .rk_ena            (rk_ena),
      .rk_wea            (rk_wea),
      .rk_addra          (rk_addra),
      .rk_dina           (rk_dina),
      .frame_leaked_info (frame_leaked_info),
      .frame_error_count (frame_error_count),
      .frame_param_valid (frame_param_valid),
      .frame_verif_fail  (frame_verif_fail),
      .pa_valid          (pa_valid),
      .pa_ready          (pa_ready),
      .pa_base_addr      (pa_base_addr),
      .pa_word_cnt       (pa_word_cnt),
      .pa_secure_len     (pa_secure_len),
      .pa_status         (pa_status),
      .pa_parity         (pa_parity),
      .overflow_err      (overflow_err),
      .protocol_err      (protocol_err),
      .frames_done       (frames_done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [13:0] exp_sec(input int leaked);
      int d;
      d = 8192 - leaked - 64;
      if (d < 0) return 14'd0;
      if (d > 16383) return 14'h3FFF;
      return 14'(d);
   endfunction

   // Transfer happens on the next rising edge; inputs are stable at the falling edge.
   always @(negedge clk) begin
      desc_t e;
      if (rst_n && pa_valid && pa_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_desc", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("base", 64'(pa_base_addr), 64'(e.base));
            chk("word_cnt", 64'(pa_word_cnt), 64'(e.cnt));
            chk("secure_len", 64'(pa_secure_len), 64'(e.sec));
            chk("status", 64'(pa_status), 64'(e.st));
            chk("parity", 64'(pa_parity), 64'(e.par));
         end
      end
   end

   task automatic write_word(input logic [14:0] addr, output logic p);
      logic [63:0] d;
      d        = {$urandom, $urandom};
      rk_ena   = 1'b1;
      rk_wea   = 1'b1;
      rk_addra = addr;
      rk_dina  = d;
      p        = ^d;
   endtask

   task automatic run_frame(input logic [14:0] start, input int n, input int leaked, input int errs,
                            input logic fail, input bit coincide, input bit drop,
                            input bit extra_pulse, input bit lat_chk);
      desc_t e;
      logic  p, wp;
      int    nw;
      p  = 1'b0;
      nw = coincide ? n - 1 : n;
      for (int i = 0; i < nw; i++) begin
         write_word(start + 15'(i), wp);
         p = p ^ wp;
         @(posedge clk); #1;
      end
      rk_ena = 1'b0;
      rk_wea = 1'b0;
      if (coincide) begin
         write_word(start + 15'(n - 1), wp);
         p = p ^ wp;
      end
      frame_leaked_info = 16'(leaked);
      frame_error_count = 12'(errs);
      frame_verif_fail  = fail;
      frame_param_valid = 1'b1;
      e.base = start;
      e.cnt  = 16'(n);
      e.st   = {n != 128, fail, errs > 901};
      e.sec  = (e.st != 3'b000) ? 14'd0 : exp_sec(leaked);
      e.par  = p;
      if (!drop) begin
         exp_q.push_back(e);
         exp_done++;
      end
      @(posedge clk); #1;
      frame_param_valid = 1'b0;
      frame_verif_fail  = 1'b0;
      rk_ena = 1'b0;
      rk_wea = 1'b0;
      if (extra_pulse) begin
         frame_param_valid = 1'b1;
         @(posedge clk); #1;
         frame_param_valid = 1'b0;
         @(posedge clk); #1;
      end else begin
         @(posedge clk); #1;
         if (lat_chk) chk("lat_early", 64'(pa_valid), 64'd0);
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 64'(pa_valid), 64'd0);
      chk({tag, "_base"}, 64'(pa_base_addr), 64'd0);
      chk({tag, "_cnt"}, 64'(pa_word_cnt), 64'd0);
      chk({tag, "_sec"}, 64'(pa_secure_len), 64'd0);
      chk({tag, "_status"}, 64'(pa_status), 64'd0);
      chk({tag, "_parity"}, 64'(pa_parity), 64'd0);
      chk({tag, "_ovf"}, 64'(overflow_err), 64'd0);
      chk({tag, "_proto"}, 64'(protocol_err), 64'd0);
      chk({tag, "_done"}, 64'(frames_done), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic wp;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Clean frame with latency check while PA stalls.
      run_frame(15'h0100, 128, 1200, 300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("lat_valid", 64'(pa_valid), 64'd1);
      chk("clean_sec_hold", 64'(pa_secure_len), 64'd6928);
      chk("clean_base_hold", 64'(pa_base_addr), 64'h0100);
      pa_ready = 1'b1;
      wait_drain();

      // Saturation, QBER abort, malformed, verification fail.
      run_frame(15'h0200, 128, 8200, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame(15'h0300, 128, 1200, 902, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame(15'h0400, 127, 1000, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame(15'h0500, 128, 1000, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame(15'h0580, 128, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_drain();

      // Coincident write, early second pulse, address wrap.
      chk("proto_before", 64'(protocol_err), 64'd0);
      run_frame(15'h0600, 128, 1200, 300, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      wait_drain();
      chk("proto_after", 64'(protocol_err), 64'd1);
      run_frame(15'h7FC0, 128, 2000, 50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_drain();
      chk("done_mid", 64'(frames_done), 64'(exp_done));
      chk("ovf_before", 64'(overflow_err), 64'd0);

      // Backpressure: five frames into a four-deep FIFO.
      pa_ready = 1'b0;
      for (int f = 0; f < 5; f++) begin
         run_frame(15'(16'h1000 + f * 128), 128, 1000 + f * 100, 100 + f, 1'b0, 1'b0,
                   (f == 4), 1'b0, 1'b0);
      end
      chk("bp_valid", 64'(pa_valid), 64'd1);
      chk("bp_ovf", 64'(overflow_err), 64'd1);
      chk("bp_done", 64'(frames_done), 64'(exp_done));
      pa_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("drain_valid", 64'(pa_valid), 64'd1);
      end
      @(negedge clk);
      chk("drain_empty", 64'(pa_valid), 64'd0);
      chk("drain_queue", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;

      // Reset mid-frame with a descriptor still held in the FIFO.
      pa_ready = 1'b0;
      run_frame(15'h2000, 128, 1200, 300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 60; i++) begin
         write_word(15'h2100 + 15'(i), wp);
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      exp_q.delete();
      exp_done = 0;
      #1;
      chk_all_zero("midreset");
      rk_ena = 1'b0;
      rk_wea = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      pa_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_reset_empty", 64'(pa_valid), 64'd0);
      run_frame(15'h3000, 128, 1200, 300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_drain();
      chk("post_reset_done", 64'(frames_done), 64'(exp_done));

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
